fixed_point_mac: RTL and testbench
==================================

FIXED_POINT_MAC -- requirements
Module: fixed_point_mac

Interface
REQ-001 Parameter IN_W, default 8: width of the signed operands a and b.
REQ-002 Parameter ACC_W, default 16: width of the signed accumulator; it SHALL equal 2*IN_W.
REQ-003 Parameter CNT_W, default 8: width of the term counter.
REQ-004 clk  input  1  rising-edge clock; this is the block's only clock.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 a  input  IN_W  signed operand A, two's complement.
REQ-007 b  input  IN_W  signed operand B, two's complement.
REQ-008 in_valid  input  1  a, b and in_last are valid this cycle.
REQ-009 in_last  input  1  this term is the final term of the dot product.
REQ-010 in_ready  output  1  block accepts a term this cycle.
REQ-011 out_data  output  ACC_W  saturated signed dot-product result; feeds the downstream rounding stage (16 to 12 bits).
REQ-012 out_ovf  output  1  sticky flag: saturation occurred at least once during this dot product.
REQ-013 out_count  output  CNT_W  number of accepted terms, saturating at 2^CNT_W-1.
REQ-014 out_valid  output  1  out_data, out_ovf and out_count are valid.
REQ-015 out_ready  input  1  downstream accepts the result.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACC and OUT.
REQ-017 A term SHALL be accepted exactly on a rising edge where in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 in IDLE and ACC, and 0 in OUT.
REQ-019 out_valid SHALL be 1 only in OUT; it SHALL be driven from a register, not combinationally from inputs.
REQ-020 Product p = a*b SHALL be computed as a full-precision signed value of ACC_W bits (range -16256..16384 for IN_W=8).
REQ-021 On each accepted term: acc <= sat(base + p), where base is 0 in IDLE and acc in ACC.
  - sat() clamps the result to [-2^(ACC_W-1), 2^(ACC_W-1)-1], i.e. [-32768, 32767].
  - Overflow is detected on the ACC_W+1-bit sum.
REQ-022 Saturation SHALL be applied per step; a later term may bring a clamped value back into range.
REQ-023 On each accepted term: ovf <= (base_ovf OR clamp occurred), where base_ovf is 0 in IDLE.
REQ-024 On each accepted term: count <= 1 in IDLE; in ACC, count <= count+1, holding at 2^CNT_W-1.
REQ-025 Transition on an accepted term with in_last=0: IDLE->ACC, or ACC->ACC.
REQ-026 Transition on an accepted term with in_last=1: IDLE->OUT, or ACC->OUT.
REQ-027 Latency: out_valid=1 on the cycle after the last term is accepted, with out_data already including that term.
REQ-028 In IDLE and ACC with in_valid=0, all state SHALL hold.
REQ-029 In OUT, out_data, out_ovf and out_count SHALL be stable while out_ready=0, and in_valid SHALL be ignored.
REQ-030 In OUT with out_ready=1, the next state SHALL be IDLE, and acc, ovf and count SHALL clear to 0.
REQ-031 The cycle after an OUT->IDLE transition SHALL accept a new term, giving a throughput of one result per (N terms + 1) cycles.
REQ-032 Outside OUT, out_data, out_ovf and out_count SHALL reflect the internal registers; they are qualified only by out_valid.
REQ-033 Operands are already two's complement, so a=-128 with b=-128 SHALL yield p=+16384 with no internal overflow.

Reset
REQ-034 While rst_n=0, independent of clk: state=IDLE, acc=0, ovf=0, count=0, out_valid=0, in_ready=1.
REQ-035 A reset asserted mid-accumulation or in OUT SHALL discard the partial or pending result; there SHALL be no out_valid pulse afterwards.
REQ-036 The first edge after rst_n deasserts SHALL be able to accept a term.

Verification
REQ-037 Reset: rst_n=0 for 3 cycles, then release -> out_valid=0, in_ready=1, out_data=0, out_count=0.
REQ-038 Single term: a=3, b=4, in_last=1 -> next cycle out_valid=1, out_data=12, out_count=1, out_ovf=0.
REQ-039 Three terms: (10,10), (-5,4), (7,-3, last) -> out_data=59, out_count=3, out_ovf=0.
REQ-040 Saturation: three terms (-128,-128), last on the third -> out_data=32767, out_ovf=1, out_count=3.
  - Negative variant: three terms (-128,127) -> -16256, -32512, then clamp -> out_data=-32768, out_ovf=1.
  - Recovery variant: (127,-128)x3 then (127,127, last) -> out_data=-32768+16129=-16639, out_ovf=1.
REQ-041 Backpressure: hold out_ready=0 for 5 cycles in OUT while in_valid=1 -> out_valid stays 1, outputs stable, in_ready=0, no term accepted; on out_ready=1, IDLE the next cycle.
REQ-042 Reset mid-accumulation: after 2 of 4 terms, pulse rst_n low between clock edges -> outputs clear immediately; the following 1-term packet (2,-3) -> out_data=-6, out_count=1.

Source files
------------

// File: rtl/fixed_point_mac.sv
// -----------------------------------------------------------------------------
// fixed_point_mac
//   Signed fixed-point multiply-accumulate engine for dot products. Terms
//   (a, b) stream in under a valid/ready handshake; every accepted term adds
//   the full-precision product a*b into a saturating accumulator. The term
//   flagged by i_in_last closes the dot product: the result is then presented
//   under a valid/ready handshake. out_data feeds a downstream 16->12 bit
//   rounding stage.
//
//   ACC_W must equal 2*IN_W. The product of two IN_W-bit signed operands then
//   always fits in ACC_W bits, including (-2^(IN_W-1))^2.
//
// Ports
//   i_clk        rising-edge clock, the only clock
//   i_rst_n      asynchronous active-low reset
//   i_a, i_b     signed operands (two's complement, IN_W bits)
//   i_in_valid   a, b and in_last are valid this cycle
//   i_in_last    current term is the final term of the dot product
//   o_in_ready   a term is accepted this cycle (1 in IDLE/ACC, 0 in OUT)
//   o_out_data   saturated signed accumulator (ACC_W bits)
//   o_out_ovf    sticky: saturation occurred during this dot product
//   o_out_count  accepted terms, saturating at 2^CNT_W-1
//   o_out_valid  out_data/out_ovf/out_count hold a finished result
//   i_out_ready  downstream takes the result
// -----------------------------------------------------------------------------
module fixed_point_mac #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic signed [IN_W-1:0]  i_a,
  input  logic signed [IN_W-1:0]  i_b,
  input  logic                    i_in_valid,
  input  logic                    i_in_last,
  output logic                    o_in_ready,
  output logic signed [ACC_W-1:0] o_out_data,
  output logic                    o_out_ovf,
  output logic [CNT_W-1:0]        o_out_count,
  output logic                    o_out_valid,
  input  logic                    i_out_ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // The ACC_W+1-bit sum overflows when its two top bits disagree.
  function automatic logic sum_ovf_f(input logic [ACC_W:0] s);
    return s[ACC_W] ^ s[ACC_W-1];
  endfunction

  // Clamp the ACC_W+1-bit sum into the ACC_W-bit signed range.
  function automatic logic [ACC_W-1:0] sat_f(input logic [ACC_W:0] s);
    logic [ACC_W-1:0] v;
    if (sum_ovf_f(s)) begin
      v = s[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      v = s[ACC_W-1:0];
    end
    return v;
  endfunction

  state_t                  r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_ovf;
  logic [CNT_W-1:0]        r_count;
  logic                    r_in_ready;
  logic                    r_out_valid;

  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    w_ovf_nxt;
  logic [CNT_W-1:0]        w_count_nxt;

  logic signed [ACC_W-1:0] w_a_ext;
  logic signed [ACC_W-1:0] w_b_ext;
  logic signed [ACC_W-1:0] w_p;
  logic signed [ACC_W-1:0] w_base;
  logic                    w_base_ovf;
  logic [ACC_W:0]          w_sum;
  logic [CNT_W-1:0]        w_cnt_inc;

  // Sign-extend the operands so the ACC_W-bit product is exact.
  assign w_a_ext = {{(ACC_W-IN_W){i_a[IN_W-1]}}, i_a};
  assign w_b_ext = {{(ACC_W-IN_W){i_b[IN_W-1]}}, i_b};
  assign w_p     = w_a_ext * w_b_ext;

  // A new dot product starts from zero; only ACC continues the running sum.
  assign w_base     = (r_state == ST_ACC) ? r_acc : {ACC_W{1'b0}};
  assign w_base_ovf = (r_state == ST_ACC) ? r_ovf : 1'b0;
  assign w_sum      = {w_base[ACC_W-1], w_base} + {w_p[ACC_W-1], w_p};
  assign w_cnt_inc  = (r_count == CNT_MAX) ? CNT_MAX : (r_count + CNT_ONE);

  // Next-state and datapath update selection.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE, ST_ACC: begin
        if (i_in_valid) begin
          w_acc_nxt   = sat_f(w_sum);
          w_ovf_nxt   = w_base_ovf | sum_ovf_f(w_sum);
          w_count_nxt = (r_state == ST_IDLE) ? CNT_ONE : w_cnt_inc;
          w_state_nxt = i_in_last ? ST_OUT : ST_ACC;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_OUT: begin
        if (i_out_ready) begin
          w_state_nxt = ST_IDLE;
          w_acc_nxt   = {ACC_W{1'b0}};
          w_ovf_nxt   = 1'b0;
          w_count_nxt = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = {ACC_W{1'b0}};
        w_ovf_nxt   = 1'b0;
        w_count_nxt = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, datapath and handshake registers; handshakes follow the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= {ACC_W{1'b0}};
      r_ovf       <= 1'b0;
      r_count     <= {CNT_W{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_ovf       <= w_ovf_nxt;
      r_count     <= w_count_nxt;
      r_in_ready  <= (w_state_nxt != ST_OUT);
      r_out_valid <= (w_state_nxt == ST_OUT);
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_acc;
  assign o_out_ovf   = r_ovf;
  assign o_out_count = r_count;

endmodule

// File: tb/tb_fixed_point_mac.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_mac
//   Self-checking bench for fixed_point_mac. A behavioural model tracks the
//   running dot product with plain integer arithmetic; a compare process
//   checks every DUT output against it on each falling edge. Directed packets
//   pin the model with hand-computed literals, then a randomized phase
//   exercises the handshakes and saturation.
// -----------------------------------------------------------------------------
module tb_fixed_point_mac;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [7:0]  a = 8'sd0;
  logic signed [7:0]  b = 8'sd0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b0;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_ovf;
  logic [7:0]         out_count;
  logic               out_valid;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: running sum, sticky flag, term count, result pending.
  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  bit m_out = 1'b0;
  bit cmp_en = 1'b0;

  fixed_point_mac #(.IN_W(8), .ACC_W(16), .CNT_W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_a         (a),
    .i_b         (b),
    .i_in_valid  (in_valid),
    .i_in_last   (in_last),
    .o_in_ready  (in_ready),
    .o_out_data  (out_data),
    .o_out_ovf   (out_ovf),
    .o_out_count (out_count),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Unclamped sum of this term; a dot product with no terms yet starts at 0.
  function automatic int raw_sum(input int cnt, input int acc, input int x, input int y);
    return ((cnt == 0) ? 0 : acc) + x * y;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model update on each accepted term or result hand-off.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_acc <= 0;
      m_cnt <= 0;
      m_ovf <= 1'b0;
      m_out <= 1'b0;
    end else if (m_out) begin
      if (out_ready) begin
        m_acc <= 0;
        m_cnt <= 0;
        m_ovf <= 1'b0;
        m_out <= 1'b0;
      end
    end else if (in_valid) begin
      m_acc <= clamp16(raw_sum(m_cnt, m_acc, int'(a), int'(b)));
      m_ovf <= ((m_cnt == 0) ? 1'b0 : m_ovf) |
               (raw_sum(m_cnt, m_acc, int'(a), int'(b)) !=
                clamp16(raw_sum(m_cnt, m_acc, int'(a), int'(b))));
      m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1;
      m_out <= in_last;
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("in_ready",  int'(in_ready),  int'(!m_out));
      check("out_valid", int'(out_valid), int'(m_out));
      check("out_data",  int'(out_data),  m_acc);
      check("out_ovf",   int'(out_ovf),   int'(m_ovf));
      check("out_count", int'(out_count), m_cnt);
    end
  end

  task automatic term(input int ta, input int tb_v, input bit last);
    @(negedge clk);
    a        = ta[7:0];
    b        = tb_v[7:0];
    in_valid = 1'b1;
    in_last  = last;
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) check({nm, "_timeout"}, 0, 1);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string nm, input int d, input int o, input int c);
    check({nm, "_valid"}, int'(out_valid), 1);
    check({nm, "_data"},  int'(out_data),  d);
    check({nm, "_ovf"},   int'(out_ovf),   o);
    check({nm, "_count"}, int'(out_count), c);
  endtask

  function automatic logic [7:0] rand_op();
    int r;
    r = int'($urandom_range(255, 0));
    case ($urandom_range(3, 0))
      0:       r = 128;
      1:       r = 127;
      default: r = r;
    endcase
    return r[7:0];
  endfunction

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_in_ready",  int'(in_ready),  1);
    check("rst_hold_out_valid", int'(out_valid), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_in_ready",  int'(in_ready),  1);
    check("reset_out_data",  int'(out_data),  0);
    check("reset_out_count", int'(out_count), 0);

    // Single term: result visible on the first cycle after acceptance.
    term(3, 4, 1'b1);
    idle_in();
    check_result("single", 12, 0, 1);
    drain();

    term(10, 10, 1'b0);
    term(-5, 4, 1'b0);
    term(7, -3, 1'b1);
    idle_in();
    wait_out("three");
    check_result("three", 59, 0, 3);
    drain();

    for (int i = 0; i < 3; i++) term(-128, -128, i == 2);
    idle_in();
    wait_out("sat_pos");
    check_result("sat_pos", 32767, 1, 3);
    drain();

    for (int i = 0; i < 3; i++) term(-128, 127, i == 2);
    idle_in();
    wait_out("sat_neg");
    check_result("sat_neg", -32768, 1, 3);
    drain();

    for (int i = 0; i < 3; i++) term(127, -128, 1'b0);
    term(127, 127, 1'b1);
    idle_in();
    wait_out("recover");
    check_result("recover", -16639, 1, 4);
    drain();

    // Backpressure: in OUT, terms offered while out_ready=0 are ignored.
    term(1, 2, 1'b1);
    idle_in();
    wait_out("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a         = rand_op();
      b         = rand_op();
      in_valid  = 1'b1;
      in_last   = 1'($urandom_range(1, 0));
      out_ready = 1'b0;
      check("bp_in_ready", int'(in_ready), 0);
      check_result("bp", 2, 0, 1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_after_valid",    int'(out_valid), 0);
    check("bp_after_in_ready", int'(in_ready),  1);
    check("bp_after_data",     int'(out_data),  0);

    // Reset pulse between clock edges while accumulating.
    term(5, 5, 1'b0);
    term(6, 6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_partial_data",  int'(out_data),  61);
    check("mid_partial_count", int'(out_count), 2);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_data",      int'(out_data),  0);
    check("mid_rst_count",     int'(out_count), 0);
    check("mid_rst_in_ready",  int'(in_ready),  1);
    check("mid_rst_out_valid", int'(out_valid), 0);
    #1 rst_n = 1'b1;
    term(2, -3, 1'b1);
    idle_in();
    check_result("after_rst", -6, 0, 1);
    drain();

    // Term counter saturates at 255.
    for (int i = 0; i < 260; i++) term(1, 1, i == 259);
    idle_in();
    wait_out("long");
    check_result("long", 260, 0, 255);
    drain();

    // Randomized traffic checked by the model.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      a        = rand_op();
      b        = rand_op();
      if (m_out) begin
        in_valid  = 1'($urandom_range(1, 0));
        in_last   = 1'($urandom_range(1, 0));
        out_ready = ($urandom_range(2, 0) == 0);
      end else begin
        in_valid  = ($urandom_range(3, 0) != 0);
        in_last   = ($urandom_range(4, 0) == 0);
        out_ready = 1'($urandom_range(1, 0));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
